// File: rtl/innovation_gate_pkg.sv
// Shared fixed-point types, saturation limits and saturating arithmetic helpers for the
// innovation gate.
package innovation_gate_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned FRAC_BITS        = 16;
  localparam int unsigned STATE_DIM        = 4;
  localparam int unsigned MEAS_DIM_DEFAULT = 2;

  typedef logic signed [DATA_WIDTH-1:0]   fp_t;
  typedef logic signed [2*DATA_WIDTH-1:0] fp_wide_t;

  localparam fp_t FP_MAX              = fp_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam fp_t FP_MIN              = fp_t'({1'b1, {(DATA_WIDTH-1){1'b0}}});
  localparam fp_t GATE_THRESH_DEFAULT = fp_t'(9) <<< FRAC_BITS;

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_CAPT  = 2'd1,
    G_ACCUM = 2'd2,
    G_FINAL = 2'd3
  } gate_state_t;

  function automatic fp_t fp_add_sat(input fp_t a, input fp_t b, output logic ovf);
    logic signed [DATA_WIDTH:0] s;
    s   = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    ovf = s[DATA_WIDTH] ^ s[DATA_WIDTH-1];
    if (!ovf)               return s[DATA_WIDTH-1:0];
    else if (s[DATA_WIDTH]) return FP_MIN;
    else                    return FP_MAX;
  endfunction

  function automatic fp_t fp_sub_sat(input fp_t a, input fp_t b, output logic ovf);
    logic signed [DATA_WIDTH:0] s;
    s   = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    ovf = s[DATA_WIDTH] ^ s[DATA_WIDTH-1];
    if (!ovf)               return s[DATA_WIDTH-1:0];
    else if (s[DATA_WIDTH]) return FP_MIN;
    else                    return FP_MAX;
  endfunction

  // Full-width product, rescaled; fits only if every bit above the result sign matches it.
  function automatic fp_t fp_mul_sat(input fp_t a, input fp_t b, output logic ovf);
    fp_wide_t p;
    p   = (fp_wide_t'(a) * fp_wide_t'(b)) >>> FRAC_BITS;
    ovf = !((&p[2*DATA_WIDTH-1:DATA_WIDTH-1]) || !(|p[2*DATA_WIDTH-1:DATA_WIDTH-1]));
    if (!ovf)                   return p[DATA_WIDTH-1:0];
    else if (p[2*DATA_WIDTH-1]) return FP_MIN;
    else                        return FP_MAX;
  endfunction

endpackage

// File: rtl/innovation_gate_if.sv
// Request/result bundle between the track-predict datapath and the innovation gate.
interface innovation_gate_if
  import innovation_gate_pkg::*;
#(
  parameter int unsigned MEAS_DIM = MEAS_DIM_DEFAULT
);
  logic start;
  fp_t  x_pred [STATE_DIM];
  fp_t  z      [MEAS_DIM];
  fp_t  s_inv  [MEAS_DIM];
  logic busy;
  logic done;
  fp_t  resid  [MEAS_DIM];
  fp_t  d2;
  logic in_gate;
  logic overflow;

  modport master (
    output start, x_pred, z, s_inv,
    input  busy, done, resid, d2, in_gate, overflow
  );

  modport slave (
    input  start, x_pred, z, s_inv,
    output busy, done, resid, d2, in_gate, overflow
  );
endinterface

// File: rtl/innovation_gate_mac.sv
// Multiply-rescale-saturate stage fed from registered operands; two are chained per term.
module innovation_gate_mac
  import innovation_gate_pkg::*;
(
  input  fp_t  a_i,
  input  fp_t  b_i,
  output fp_t  p_o,
  output logic ovf_o
);
  fp_t  p;
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    p   = fp_mul_sat(a_i, b_i, ovf);
  end

  assign p_o   = p;
  assign ovf_o = ovf;
endmodule

// File: rtl/innovation_gate.sv
// Residual r = z - H x_pred and diagonal-weighted distance d2, one term per cycle, with a
// gate decision on d2 <= GATE_THRESH.
module innovation_gate
  import innovation_gate_pkg::*;
#(
  parameter int unsigned MEAS_DIM    = MEAS_DIM_DEFAULT,
  parameter fp_t         GATE_THRESH = GATE_THRESH_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  innovation_gate_if.slave gate_io
);
  localparam int unsigned KW = (MEAS_DIM > 1) ? $clog2(MEAS_DIM) : 1;

  localparam logic [1:0] StIdle  = G_IDLE;
  localparam logic [1:0] StCapt  = G_CAPT;
  localparam logic [1:0] StAccum = G_ACCUM;
  localparam logic [1:0] StFinal = G_FINAL;

  logic [1:0]    state_q, state_d;
  fp_t           acc_q, acc_d;
  logic [KW-1:0] k_q, k_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  fp_t           d2_q, d2_d;
  logic          in_gate_q, in_gate_d;
  logic          overflow_q, overflow_d;

  fp_t           resid_arr [MEAS_DIM];
  fp_t           s_arr     [MEAS_DIM];
  logic [MEAS_DIM-1:0] r_ovf_vec;

  // FINAL also accepts so back-to-back requests run without an idle cycle.
  logic accept;
  assign accept = gate_io.start && ((state_q == StIdle) || (state_q == StFinal));

  for (genvar k = 0; k < MEAS_DIM; k++) begin : g_meas
    fp_t  z_q, xp_q, s_q, resid_q, r_sat;
    logic r_ovf;

    always_comb begin
      r_ovf = 1'b0;
      r_sat = fp_sub_sat(z_q, xp_q, r_ovf);
    end

    // Negative weights are clamped on capture; the clamp is not an overflow.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        z_q     <= '0;
        xp_q    <= '0;
        s_q     <= '0;
        resid_q <= '0;
      end else begin
        if (accept) begin
          z_q  <= gate_io.z[k];
          xp_q <= gate_io.x_pred[2*k];
          s_q  <= gate_io.s_inv[k][DATA_WIDTH-1] ? '0 : gate_io.s_inv[k];
        end
        if (state_q == StCapt) resid_q <= r_sat;
      end
    end

    assign resid_arr[k]     = resid_q;
    assign s_arr[k]         = s_q;
    assign r_ovf_vec[k]     = r_ovf;
    assign gate_io.resid[k] = resid_q;
  end

  fp_t  sq, term, acc_sum;
  logic sq_ovf, term_ovf, add_ovf;

  innovation_gate_mac u_square (
    .a_i   (resid_arr[k_q]),
    .b_i   (resid_arr[k_q]),
    .p_o   (sq),
    .ovf_o (sq_ovf)
  );

  innovation_gate_mac u_weight (
    .a_i   (sq),
    .b_i   (s_arr[k_q]),
    .p_o   (term),
    .ovf_o (term_ovf)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    k_d        = k_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    d2_d       = d2_q;
    in_gate_d  = in_gate_q;
    overflow_d = overflow_q;
    add_ovf    = 1'b0;
    acc_sum    = fp_add_sat(acc_q, term, add_ovf);

    unique case (state_q)
      StIdle: begin
        if (gate_io.start) begin
          state_d = StCapt;
          busy_d  = 1'b1;
        end
      end
      StCapt: begin
        acc_d   = '0;
        k_d     = '0;
        ovf_d   = |r_ovf_vec;
        state_d = StAccum;
      end
      StAccum: begin
        acc_d = acc_sum;
        ovf_d = ovf_q | sq_ovf | term_ovf | add_ovf;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(MEAS_DIM - 1)) state_d = StFinal;
      end
      StFinal: begin
        d2_d       = acc_q;
        overflow_d = ovf_q;
        in_gate_d  = !ovf_q && (acc_q <= GATE_THRESH);
        done_d     = 1'b1;
        busy_d     = gate_io.start;
        state_d    = gate_io.start ? StCapt : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      k_q        <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      d2_q       <= '0;
      in_gate_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      d2_q       <= d2_d;
      in_gate_q  <= in_gate_d;
      overflow_q <= overflow_d;
    end
  end

  assign gate_io.busy     = busy_q;
  assign gate_io.done     = done_q;
  assign gate_io.d2       = d2_q;
  assign gate_io.in_gate  = in_gate_q;
  assign gate_io.overflow = overflow_q;
endmodule

// File: tb/tb_innovation_gate.sv
// Self-checking bench for innovation_gate: directed cases plus randomized transactions
// against an integer-arithmetic reference model.
module tb_innovation_gate
  import innovation_gate_pkg::*;
;
  localparam int unsigned MD = MEAS_DIM_DEFAULT;

  typedef fp_t meas_arr_t  [MD];
  typedef fp_t state_arr_t [STATE_DIM];

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  innovation_gate_if #(.MEAS_DIM(MD)) gif ();

  innovation_gate #(
    .MEAS_DIM    (MD),
    .GATE_THRESH (GATE_THRESH_DEFAULT)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gate_io (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fp_t fx(input int v);
    return fp_t'(v) <<< FRAC_BITS;
  endfunction

  function automatic fp_t rnd_val(input int unsigned span);
    int v;
    if ($urandom_range(0, 15) == 0) return fp_t'($urandom());
    v = int'($urandom_range(0, (2 * span) << FRAC_BITS)) - int'(span << FRAC_BITS);
    return fp_t'(v);
  endfunction

  // Reference: exact integer arithmetic with clamping to the fp_t range at each stage.
  function automatic void model(input state_arr_t xp, input meas_arr_t zz, input meas_arr_t ss,
                                output meas_arr_t r, output fp_t d, output logic ig,
                                output logic ov);
    longint mx, acc, v, sq, t, s;
    mx  = longint'(FP_MAX);
    ov  = 1'b0;
    acc = 0;
    for (int k = 0; k < MD; k++) begin
      v = longint'(zz[k]) - longint'(xp[2*k]);
      if (v > mx) begin v = mx; ov = 1'b1; end
      else if (v < -mx - 1) begin v = -mx - 1; ov = 1'b1; end
      r[k] = fp_t'(v);
      sq = (v * v) >>> FRAC_BITS;
      if (sq > mx) begin sq = mx; ov = 1'b1; end
      s = (ss[k] < 0) ? 0 : longint'(ss[k]);
      t = (sq * s) >>> FRAC_BITS;
      if (t > mx) begin t = mx; ov = 1'b1; end
      acc = acc + t;
      if (acc > mx) begin acc = mx; ov = 1'b1; end
    end
    d  = fp_t'(acc);
    ig = !ov && (acc <= longint'(GATE_THRESH_DEFAULT));
  endfunction

  // Drives one request from IDLE and returns edges from acceptance to done, -1 on timeout.
  task automatic run_txn(input state_arr_t xp, input meas_arr_t zz, input meas_arr_t ss,
                         output int lat);
    gif.x_pred = xp;
    gif.z      = zz;
    gif.s_inv  = ss;
    gif.start  = 1'b1;
    @(posedge clk); #1;
    gif.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (gif.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_vec++; if (gif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", gif.busy); end
    n_vec++; if (gif.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", gif.done); end
    n_vec++; if (gif.d2 !== '0) begin n_err++; $display("FAIL reset_d2: got %h want 0", gif.d2); end
    n_vec++; if (gif.in_gate !== 1'b0) begin n_err++; $display("FAIL reset_in_gate: got %b want 0", gif.in_gate); end
    n_vec++; if (gif.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", gif.overflow); end
    for (int k = 0; k < MD; k++) begin
      n_vec++;
      if (gif.resid[k] !== '0) begin n_err++; $display("FAIL reset_resid%0d: got %h want 0", k, gif.resid[k]); end
    end
  endtask

  task automatic test_basic();
    state_arr_t xp;
    meas_arr_t  zz, ss;
    int         lat;
    xp = '{fx(1), fx(0), fx(2), fx(0)};
    zz = '{fx(2), fx(4)};
    ss = '{fx(1), fp_t'(32768)};
    run_txn(xp, zz, ss, lat);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
    n_vec++; if (gif.resid[0] !== fx(1)) begin n_err++; $display("FAIL basic_resid0: got %h want %h", gif.resid[0], fx(1)); end
    n_vec++; if (gif.resid[1] !== fx(2)) begin n_err++; $display("FAIL basic_resid1: got %h want %h", gif.resid[1], fx(2)); end
    n_vec++; if (gif.d2 !== fx(3)) begin n_err++; $display("FAIL basic_d2: got %h want %h", gif.d2, fx(3)); end
    n_vec++; if (gif.in_gate !== 1'b1) begin n_err++; $display("FAIL basic_in_gate: got %b want 1", gif.in_gate); end
    n_vec++; if (gif.overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %b want 0", gif.overflow); end
    n_vec++; if (gif.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", gif.busy); end
    @(posedge clk); #1;
    n_vec++; if (gif.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", gif.done); end
    @(posedge clk); #1;
    n_vec++; if (gif.d2 !== fx(3)) begin n_err++; $display("FAIL basic_d2_held: got %h want %h", gif.d2, fx(3)); end
  endtask

  task automatic test_outside();
    state_arr_t xp;
    meas_arr_t  zz, ss;
    int         lat;
    xp = '{default: '0};
    zz = '{fx(4), fx(0)};
    ss = '{fx(1), fx(1)};
    run_txn(xp, zz, ss, lat);
    n_vec++; if (gif.d2 !== fx(16)) begin n_err++; $display("FAIL outside_d2: got %h want %h", gif.d2, fx(16)); end
    n_vec++; if (gif.in_gate !== 1'b0) begin n_err++; $display("FAIL outside_in_gate: got %b want 0", gif.in_gate); end
  endtask

  task automatic test_boundary();
    state_arr_t xp;
    meas_arr_t  zz, ss;
    int         lat;
    xp = '{default: '0};
    ss = '{fx(1), fx(1)};
    zz = '{fx(3), fx(0)};
    run_txn(xp, zz, ss, lat);
    n_vec++; if (gif.d2 !== fx(9)) begin n_err++; $display("FAIL bound_d2: got %h want %h", gif.d2, fx(9)); end
    n_vec++; if (gif.in_gate !== 1'b1) begin n_err++; $display("FAIL bound_eq_in_gate: got %b want 1", gif.in_gate); end
    zz = '{fx(3) + fp_t'(66), fx(0)};
    run_txn(xp, zz, ss, lat);
    n_vec++; if (gif.in_gate !== 1'b0) begin n_err++; $display("FAIL bound_above_in_gate: got %b want 0", gif.in_gate); end
  endtask

  task automatic test_saturation();
    state_arr_t xp;
    meas_arr_t  zz, ss;
    int         lat;
    xp = '{FP_MIN, fx(0), fx(0), fx(0)};
    zz = '{FP_MAX, fx(0)};
    ss = '{fx(1), fx(1)};
    run_txn(xp, zz, ss, lat);
    n_vec++; if (gif.resid[0] !== FP_MAX) begin n_err++; $display("FAIL sat_resid0: got %h want %h", gif.resid[0], FP_MAX); end
    n_vec++; if (gif.overflow !== 1'b1) begin n_err++; $display("FAIL sat_overflow: got %b want 1", gif.overflow); end
    n_vec++; if (gif.d2 !== FP_MAX) begin n_err++; $display("FAIL sat_d2: got %h want %h", gif.d2, FP_MAX); end
    n_vec++; if (gif.in_gate !== 1'b0) begin n_err++; $display("FAIL sat_in_gate: got %b want 0", gif.in_gate); end
  endtask

  task automatic test_back_to_back();
    state_arr_t  xp;
    meas_arr_t   zz, ss;
    logic [15:0] seen;
    logic [15:0] want;
    xp   = '{default: '0};
    zz   = '{fx(2), fx(1)};
    ss   = '{-fx(1), fx(1)};
    seen = '0;
    want = 16'h1110;  // done after edges 4, 8 and 12
    gif.x_pred = xp;
    gif.z      = zz;
    gif.s_inv  = ss;
    gif.start  = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      seen[c] = gif.done;
      if (gif.done) begin
        n_vec++;
        if (gif.d2 !== fx(1)) begin n_err++; $display("FAIL b2b_d2@%0d: got %h want %h", c, gif.d2, fx(1)); end
      end
      if (c == 9) gif.start = 1'b0;
    end
    n_vec++; if (seen !== want) begin n_err++; $display("FAIL b2b_done_cycles: got %h want %h", seen, want); end
  endtask

  task automatic test_random();
    state_arr_t xp;
    meas_arr_t  zz, ss, r;
    fp_t        d;
    logic       ig, ov;
    int         lat;
    int unsigned span;
    for (int t = 0; t < 40; t++) begin
      span = (t % 3 == 0) ? 2 : 8;
      for (int i = 0; i < STATE_DIM; i++) xp[i] = rnd_val(span);
      for (int k = 0; k < MD; k++) begin
        zz[k] = rnd_val(span);
        ss[k] = rnd_val(3);
      end
      model(xp, zz, ss, r, d, ig, ov);
      run_txn(xp, zz, ss, lat);
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 4", t, lat); end
      for (int k = 0; k < MD; k++) begin
        n_vec++;
        if (gif.resid[k] !== r[k]) begin n_err++; $display("FAIL rnd%0d_resid%0d: got %h want %h", t, k, gif.resid[k], r[k]); end
      end
      n_vec++; if (gif.d2 !== d) begin n_err++; $display("FAIL rnd%0d_d2: got %h want %h", t, gif.d2, d); end
      n_vec++; if (gif.in_gate !== ig) begin n_err++; $display("FAIL rnd%0d_in_gate: got %b want %b", t, gif.in_gate, ig); end
      n_vec++; if (gif.overflow !== ov) begin n_err++; $display("FAIL rnd%0d_overflow: got %b want %b", t, gif.overflow, ov); end
    end
  endtask

  task automatic test_reset_abort();
    state_arr_t xp;
    meas_arr_t  zz, ss;
    int         lat;
    logic       any_done;
    xp = '{fx(1), fx(0), fx(2), fx(0)};
    zz = '{fx(2), fx(4)};
    ss = '{fx(1), fp_t'(32768)};
    gif.x_pred = xp;
    gif.z      = zz;
    gif.s_inv  = ss;
    gif.start  = 1'b1;
    @(posedge clk); #1;
    gif.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    any_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      any_done = any_done | gif.done;
    end
    n_vec++; if (any_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b want 0", any_done); end
    run_txn(xp, zz, ss, lat);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL abort_next_latency: got %0d want 4", lat); end
    n_vec++; if (gif.d2 !== fx(3)) begin n_err++; $display("FAIL abort_next_d2: got %h want %h", gif.d2, fx(3)); end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    gif.start  = 1'b0;
    gif.x_pred = '{default: '0};
    gif.z      = '{default: '0};
    gif.s_inv  = '{default: '0};
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_outside();
    test_boundary();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
